// File: rtl/joy_pkg.sv
// -----------------------------------------------------------------------------
// joy_pkg
// Shared definitions for the board's gamepad / joystick input logic.
//   - pad_state_e : states of the NES pad latch-and-shift transaction
//   - BTN_*       : bit positions of each button in the published button vector
//   - HALF_25MHZ  : pad half-period in 25 MHz cycles (6 us)
// -----------------------------------------------------------------------------
package joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_CLK_LO = 3'd4,
    ST_DONE   = 3'd5
  } pad_state_e;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // 150 cycles of the 25 MHz pixel clock = 6 us.
  localparam int HALF_25MHZ = 150;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous board input.
//   RESET_VAL : value both flops take during reset (the input's idle level)
//   clk       : destination clock
//   reset     : asynchronous, active-high reset
//   d         : asynchronous input
//   q         : synchronized output, two cycles of latency
// -----------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// -----------------------------------------------------------------------------
// nes_pad_reader
// Reads a NES-style latch/clock/data gamepad once per poll strobe and presents
// the eight buttons as registered, active-high states.
//   HALF      : pad half-period in clk cycles (4..4095)
//   clk       : system (pixel) clock
//   reset     : asynchronous, active-high reset
//   poll      : one-cycle start strobe, ignored while a transaction runs
//   pad_data  : serial data from the pad, active-low, asynchronous
//   pad_latch : latch pulse to the pad
//   pad_clk   : shift clock to the pad, idle low
//   busy      : transaction in progress (through the valid cycle)
//   valid     : one-cycle pulse in the cycle buttons takes a new value
//   buttons   : A,B,Select,Start,Up,Down,Left,Right at bits 0..7
//   up/down/left/right : aliases of buttons[4..7]
// -----------------------------------------------------------------------------
module nes_pad_reader
  import joy_pkg::*;
#(
  parameter int HALF = HALF_25MHZ
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       busy,
  output logic       valid,
  output logic [7:0] buttons,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right
);

  localparam int TW = $clog2(2 * HALF);

  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF - 1);

  pad_state_e state_q, state_d;

  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    buttons_q, buttons_d;

  logic pad_latch_q, pad_latch_d;
  logic pad_clk_q, pad_clk_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;

  logic data_sync;
  logic half_done;

  // Pad idles high (no button pressed), so the synchronizer resets to 1.
  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_sync)
  );

  assign half_done = (timer_q == HALF_LAST);

  // ---------------------------------------------------------------------------
  // State register. The pad-facing outputs are registered from the next-state
  // decode so they change cleanly on the clock edge together with the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      // The shift register has no observable effect until all 8 bits are
      // re-sampled, but resetting it keeps simulation free of X.
      shreg_q     <= '1;
      buttons_q   <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      buttons_q   <= buttons_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: transitions, per-state timer, bit sampling.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    buttons_d = buttons_q;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (poll) begin
          state_d = ST_LATCH;
          bit_d   = '0;
        end
      end

      ST_LATCH: begin
        if (timer_q == LATCH_LAST) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end
      end

      // The pad presents A as soon as it is latched; sample it HALF cycles
      // after the latch falls.
      ST_SETTLE: begin
        if (half_done) begin
          shreg_d[bit_q] = data_sync;
          bit_d          = bit_q + 3'd1;
          state_d        = ST_CLK_HI;
          timer_d        = '0;
        end
      end

      ST_CLK_HI: begin
        if (half_done) begin
          state_d = ST_CLK_LO;
          timer_d = '0;
        end
      end

      ST_CLK_LO: begin
        if (half_done) begin
          shreg_d[bit_q] = data_sync;
          timer_d        = '0;
          if (bit_q == 3'd7) begin
            // Publish on entry to DONE so buttons changes in the valid cycle.
            buttons_d = ~{data_sync, shreg_q[6:0]};
            state_d   = ST_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_CLK_HI;
          end
        end
      end

      ST_DONE: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode of the next state; registered above.
  // ---------------------------------------------------------------------------
  always_comb begin
    pad_latch_d = (state_d == ST_LATCH);
    pad_clk_d   = (state_d == ST_CLK_HI);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_DONE);
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign buttons   = buttons_q;

  assign up    = buttons_q[BTN_UP];
  assign down  = buttons_q[BTN_DOWN];
  assign left  = buttons_q[BTN_LEFT];
  assign right = buttons_q[BTN_RIGHT];

endmodule
